// File: rtl/alu_pkg.sv
// Shared ALU op encodings, operand/result widths and request/response bundles.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package alu_pkg;

  localparam int ALU_OPND_W = 33;
  localparam int ALU_RES_W  = 32;
  localparam int ALU_OP_W   = 5;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 5'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 5'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 5'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 5'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 5'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL  = 5'd5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRL  = 5'd6;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRA  = 5'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OP_IDLE = 5'd8;

  typedef struct packed {
    logic [ALU_OPND_W-1:0] in_a;
    logic [ALU_OPND_W-1:0] in_b;
    logic [ALU_OP_W-1:0]   op;
  } alu_req_t;

  typedef struct packed {
    logic [ALU_RES_W-1:0] result;
    logic                 lt;
    logic                 ltu;
    logic                 eq;
  } alu_resp_t;

  // Encoding presented to the ALU whenever nothing is in flight.
  localparam alu_req_t ALU_REQ_IDLE = '{in_a: '0, in_b: '0, op: ALU_OP_IDLE};

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin picker: first asserted req at or after ptr, wrapping N-1 to 0.
// Latency: purely combinational.
// Backpressure: none; grant is a function of req and ptr only.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] gnt_idx
);

  int   pos;
  logic found;

  // Scan N positions starting at ptr; the first valid requester wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int off = 0; off < N; off++) begin
      pos = int'(ptr) + off;
      if (pos >= N) begin
        pos = pos - N;
      end
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        gnt_idx    = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ execute units via round-robin arbitration.
// Latency: accept at edge k, result registered at edge k+1 (resp_valid seen the cycle after next).
// Backpressure: resp_ready low stalls S2 then S1; req_ready drops once both stages are full.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ALU_OPND_W-1:0] req_in_a,
  input  logic [NUM_REQ*ALU_OPND_W-1:0] req_in_b,
  input  logic [NUM_REQ*ALU_OP_W-1:0]   req_op,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_W-1:0]               resp_id,
  output logic [ALU_RES_W-1:0]          resp_result,
  output logic                          resp_lt,
  output logic                          resp_ltu,
  output logic                          resp_eq,
  output logic [ALU_OPND_W-1:0]         alu_in_a,
  output logic [ALU_OPND_W-1:0]         alu_in_b,
  output logic [ALU_OP_W-1:0]           alu_op,
  input  logic [ALU_RES_W-1:0]          alu_result,
  input  logic                          alu_lt,
  input  logic                          alu_ltu,
  input  logic                          alu_eq
);

  alu_req_t            req_pl [NUM_REQ];
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     gnt_idx;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     ptr_nxt;
  logic                accept;

  logic                s1_valid;
  alu_req_t            s1_req;
  logic [ID_W-1:0]     s1_id;
  logic                s1_adv;
  logic                s2_adv;

  alu_req_t            alu_req;
  alu_resp_t           alu_rsp;
  alu_resp_t           resp_q;

  // Unpack the flat per-requester operand buses into request structs.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_pl[i] = '{in_a: req_in_a[ALU_OPND_W*i +: ALU_OPND_W],
                         in_b: req_in_b[ALU_OPND_W*i +: ALU_OPND_W],
                         op:   req_op[ALU_OP_W*i +: ALU_OP_W]};
  end

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_picker (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant   (grant),
    .gnt_idx (gnt_idx)
  );

  // S2 can take a new entry when empty or being drained; S1 when empty or moving on.
  assign s2_adv = !resp_valid || resp_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // Grant itself never looks at the pipeline state; only ready is gated.
  assign req_ready = grant & {NUM_REQ{s1_adv & ~flush}};
  assign accept    = |(req_valid & req_ready);

  assign ptr_nxt = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Idle encoding whenever S1 is empty, so the ALU sees a known quiet input.
  assign alu_req  = s1_valid ? s1_req : ALU_REQ_IDLE;
  assign alu_in_a = alu_req.in_a;
  assign alu_in_b = alu_req.in_b;
  assign alu_op   = alu_req.op;

  assign alu_rsp = '{result: alu_result, lt: alu_lt, ltu: alu_ltu, eq: alu_eq};

  // Issue stage: capture the granted request and advance the round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_req   <= ALU_REQ_IDLE;
      s1_id    <= '0;
      rr_ptr   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_req <= req_pl[gnt_idx];
        s1_id  <= gnt_idx;
        rr_ptr <= ptr_nxt;
      end
    end
  end

  // Response stage: register the ALU outputs; hold steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_q     <= '0;
    end else if (flush) begin
      resp_valid <= 1'b0;
    end else if (s2_adv) begin
      resp_valid <= s1_valid;
      if (s1_valid) begin
        resp_id <= s1_id;
        resp_q  <= alu_rsp;
      end
    end
  end

  assign resp_result = resp_q.result;
  assign resp_lt     = resp_q.lt;
  assign resp_ltu    = resp_q.ltu;
  assign resp_eq     = resp_q.eq;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, occupancy/round-robin model and result scoreboard.
// Latency: checks resp two edges after accept.
// Backpressure: exercises resp_ready stalls, flush and reset mid-flight.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*33-1:0] req_in_a;
  logic [N*33-1:0] req_in_b;
  logic [N*5-1:0]  req_op;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [1:0]      resp_id;
  logic [31:0]     resp_result;
  logic            resp_lt, resp_ltu, resp_eq;
  logic [32:0]     alu_in_a, alu_in_b;
  logic [4:0]      alu_op;
  logic [31:0]     alu_result;
  logic            alu_lt, alu_ltu, alu_eq;

  logic [32:0] a_arr [N];
  logic [32:0] b_arr [N];
  logic [4:0]  op_arr[N];

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entries: {id, result, lt, ltu, eq}
  logic [36:0] sb_q[$];
  logic        m_s1 = 1'b0;
  logic        m_s2 = 1'b0;
  int          m_ptr = 0;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in_a(req_in_a), .req_in_b(req_in_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_lt(resp_lt), .resp_ltu(resp_ltu), .resp_eq(resp_eq),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .alu_eq(alu_eq)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] alu_fn(input logic [32:0] a, input logic [32:0] b,
                                         input logic [4:0] op);
    logic [31:0] r;
    case (op)
      5'd0:    r = a[31:0] + b[31:0];
      5'd1:    r = a[31:0] - b[31:0];
      5'd2:    r = a[31:0] & b[31:0];
      5'd3:    r = a[31:0] | b[31:0];
      5'd4:    r = a[31:0] ^ b[31:0];
      5'd5:    r = a[31:0] << b[4:0];
      5'd6:    r = a[31:0] >> b[4:0];
      5'd7:    r = $unsigned($signed(a[31:0]) >>> b[4:0]);
      default: r = 32'd0;
    endcase
    return {r, ($signed(a) < $signed(b)), (a < b), (a == b)};
  endfunction

  // Behavioural shared ALU
  always_comb {alu_result, alu_lt, alu_ltu, alu_eq} = alu_fn(alu_in_a, alu_in_b, alu_op);

  always_comb begin
    req_in_a = '0;
    req_in_b = '0;
    req_op   = '0;
    for (int i = 0; i < N; i++) begin
      req_in_a[33*i +: 33] = a_arr[i];
      req_in_b[33*i +: 33] = b_arr[i];
      req_op[5*i +: 5]     = op_arr[i];
    end
  end

  task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model evaluated mid-cycle; predicts what the coming edge does.
  always @(negedge clk) begin : model
    logic [N-1:0] g;
    logic [N-1:0] er;
    int           gi;
    int           j;
    logic         s2a, s1a;
    g  = '0;
    gi = -1;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (gi < 0 && req_valid[j]) begin
        gi   = j;
        g[j] = 1'b1;
      end
    end
    s2a = !m_s2 || resp_ready;
    s1a = !m_s1 || s2a;
    er  = (s1a && !flush) ? g : '0;
    check_val("ready", 80'(req_ready), 80'(er));
    check_val("resp_valid", 80'(resp_valid), 80'(m_s2));
    if (!m_s1) check_val("alu_idle", 80'({alu_op, alu_in_a, alu_in_b}), 80'({5'd8, 66'd0}));
    if (reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_ptr = 0;
      sb_q.delete();
    end else if (flush) begin
      m_s1 = 1'b0; m_s2 = 1'b0;
      sb_q.delete();
    end else begin
      if (m_s2 && resp_ready) begin
        if (sb_q.size() == 0) check_val("sb_underflow", 80'(1), 80'(0));
        else check_val("resp", 80'({resp_id, resp_result, resp_lt, resp_ltu, resp_eq}),
                       80'(sb_q.pop_front()));
      end
      if (s2a) m_s2 = m_s1;
      if (s1a) m_s1 = (er != '0);
      if (er != '0) begin
        sb_q.push_back({2'(gi), alu_fn(a_arr[gi], b_arr[gi], op_arr[gi])});
        m_ptr = (gi + 1) % N;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic done;
    done = 1'b0;
    resp_ready = 1'b1;
    for (int c = 0; c < 30 && !done; c++) begin
      step();
      if (sb_q.size() == 0 && !resp_valid) done = 1'b1;
    end
    check_val(tag, 80'(done), 80'(1));
  endtask

  // Load both stages with two ops from one requester while the consumer stalls.
  task automatic fill2(input int id);
    int n;
    n = 0;
    resp_ready = 1'b0;
    req_valid[id] = 1'b1;
    for (int c = 0; c < 10 && n < 2; c++) begin
      #1;
      if (req_ready[id]) n++;
      step();
      if (n == 2) req_valid[id] = 1'b0;
      else a_arr[id] = a_arr[id] + 33'd1;
    end
    check_val("fill_cnt", 80'(n), 80'(2));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          cnt;
    logic        hit;
    logic [N-1:0] vld;
    logic [N-1:0] acc;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = 33'd10 + 33'(i); b_arr[i] = 33'd3; op_arr[i] = ALU_OP_ADD;
    end
    step();
    step();
    reset = 1'b0;

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      check_val("idle", 80'({resp_valid, req_ready, alu_op, alu_in_a, alu_in_b}),
                80'({1'b0, 4'b0, 5'd8, 66'd0}));
      step();
    end

    // Single request from requester 2
    resp_ready = 1'b1;
    a_arr[2] = 33'd5; b_arr[2] = 33'd7; op_arr[2] = ALU_OP_ADD;
    req_valid = 4'b0100;
    #1;
    check_val("t2_ready", 80'(req_ready), 80'(4'b0100));
    step();
    req_valid = '0;
    step();
    check_val("t2_resp", 80'({resp_valid, resp_id, resp_result}), 80'({1'b1, 2'd2, 32'd12}));
    drain("t2_drain");

    // All four requesters continuously valid from reset
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_arr[i] = 33'd100 * 33'(i + 1); b_arr[i] = 33'(i); op_arr[i] = 5'(i);
    end
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_val("t3_gnt", 80'(req_ready), 80'(4'b0001 << (i % 4)));
      step();
    end
    req_valid = '0;
    drain("t3_drain");

    // Stalled consumer while requester 1 streams
    a_arr[1] = 33'd100; b_arr[1] = 33'd7; op_arr[1] = ALU_OP_ADD;
    resp_ready = 1'b0;
    req_valid  = 4'b0010;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      hit = req_ready[1];
      step();
      if (hit) begin
        cnt++;
        a_arr[1] = a_arr[1] + 33'd1;
      end
    end
    check_val("t4_accepts", 80'(cnt), 80'(2));
    check_val("t4_full", 80'(req_ready), 80'(0));
    check_val("t4_hold", 80'({resp_valid, resp_id, resp_result}), 80'({1'b1, 2'd1, 32'd107}));
    resp_ready = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      #1;
      hit = req_ready[1];
      step();
    end
    check_val("t4_third", 80'(hit), 80'(1));
    req_valid = '0;
    drain("t4_drain");

    // Flush with both stages occupied
    fill2(1);
    req_valid  = 4'b0001;
    resp_ready = 1'b1;
    flush      = 1'b1;
    #1;
    check_val("t5_blocked", 80'(req_ready[0]), 80'(0));
    step();
    flush = 1'b0;
    #1;
    check_val("t5_empty", 80'({resp_valid, alu_op}), 80'({1'b0, 5'd8}));
    check_val("t5_accept", 80'(req_ready[0]), 80'(1));
    step();
    req_valid = '0;
    drain("t5_drain");

    // Reset with both stages occupied
    fill2(2);
    do_reset();
    check_val("t6_dropped", 80'(resp_valid), 80'(0));
    resp_ready = 1'b1;
    req_valid  = 4'b1001;
    #1;
    check_val("t6_gnt0", 80'(req_ready), 80'(4'b0001));
    step();
    req_valid = 4'b1000;
    #1;
    check_val("t6_gnt3", 80'(req_ready), 80'(4'b1000));
    step();
    req_valid = '0;
    drain("t6_drain");

    // Random traffic with stalls and occasional flush
    vld = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && $urandom_range(0, 2) == 0) begin
          vld[i]    = 1'b1;
          a_arr[i]  = {1'($urandom_range(0, 1)), 32'($urandom)};
          b_arr[i]  = ($urandom_range(0, 3) == 0) ? a_arr[i]
                                                  : {1'($urandom_range(0, 1)), 32'($urandom)};
          op_arr[i] = 5'($urandom_range(0, 7));
        end
      end
      req_valid  = vld;
      resp_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 40) == 0);
      #1;
      acc = req_valid & req_ready;
      step();
      vld = vld & ~acc;
    end
    flush = 1'b0;
    req_valid = '0;
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
